// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The optional trailing checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int HDR_CNT_W  = $clog2(HDR_BYTES);
    localparam int CNT_W      = $clog2(WORD_BYTES);

    localparam state_t      RST_STATE     = ST_IDLE;
    localparam logic        RST_MEM_WE    = 1'b0;
    localparam logic [31:0] RST_MEM_WDATA = 32'h0;
    localparam logic        RST_DONE      = 1'b0;
    localparam logic        RST_ERROR     = 1'b0;

    typedef struct packed {
        logic s_ready;
        logic core_hold;
        logic busy;
    } state_dec_t;

    // Status outputs are a pure decode of the state register, so none depend on s_valid.
    function automatic state_dec_t decode_state(input state_t s);
        state_dec_t d;
        d.s_ready   = (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
        d.core_hold = (s != ST_DONE);
        d.busy      = (s == ST_HDR) || (s == ST_DATA) || (s == ST_FLUSH) || (s == ST_CSUM);
        return d;
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: byte counter, lane steering and a
// registered word-complete strobe that doubles as the IMEM write enable.
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_we,
    output logic [31:0] word
);

    logic [CNT_W-1:0]                cnt;
    logic [8*(WORD_BYTES-1)-1:0]     asm_q;

    assign last_lane = (cnt == CNT_W'(WORD_BYTES - 1));

    // The completed word lands in its own register so the next word's bytes can
    // start filling asm_q while the write is still pulsing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            asm_q   <= '0;
            word_we <= RST_MEM_WE;
            word    <= RST_MEM_WDATA;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            word_we <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_en) begin
                if (last_lane) begin
                    word    <= {byte_data, asm_q};
                    word_we <= 1'b1;
                    cnt     <= '0;
                end else begin
                    for (int i = 0; i < WORD_BYTES - 1; i++) begin
                        if (cnt == CNT_W'(i)) asm_q[8*i +: 8] <= byte_data;
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into IMEM and holds the core in
// reset until it is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int MEM_DEPTH_WORDS = 1024,
    localparam int ADDR_W          = $clog2(MEM_DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH_WORDS);

    state_t              state;
    logic [HDR_CNT_W-1:0] hdr_cnt;
    logic [7:0]          hdr_lo;
    logic [ADDR_W:0]     words_left;
    logic [ADDR_W-1:0]   word_idx;
    logic                accept;
    logic                start_ok;
    logic                last_lane;
    logic [15:0]         hdr_words;

    assign {s_ready, core_hold, busy} = decode_state(state);
    assign accept    = s_valid && s_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign hdr_words = {s_data, hdr_lo};
    assign mem_waddr = word_idx;

    byte_to_word u_b2w (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .byte_en   (accept && (state == ST_DATA)),
        .byte_data (s_data),
        .last_lane (last_lane),
        .word_we   (mem_we),
        .word      (mem_wdata)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              csum <= '0;
        else if (start_ok)                    csum <= '0;
        else if (accept && state == ST_DATA)  csum <= csum + s_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_STATE;
            hdr_cnt    <= '0;
            hdr_lo     <= '0;
            words_left <= '0;
            word_idx   <= '0;
            done       <= RST_DONE;
            error      <= RST_ERROR;
        end else begin
            // Index advances after each write lands; a start (never concurrent with a write) overrides it.
            if (mem_we) word_idx <= word_idx + 1'b1;

            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_HDR;
                        hdr_cnt  <= '0;
                        word_idx <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        if (hdr_cnt != HDR_CNT_W'(HDR_BYTES - 1)) begin
                            hdr_lo  <= s_data;
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end else if (hdr_words > MAX_WORDS) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else if (hdr_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state      <= ST_DATA;
                            words_left <= hdr_words[ADDR_W:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (accept && last_lane) begin
                        words_left <= words_left - 1'b1;
                        if (words_left == (ADDR_W+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_FLUSH;
`endif
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (s_data == csum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
